// File: rtl/rf_port_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter and its scanner.
// Also holds the register-file geometry used by the RF itself.
package rf_port_arbiter_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned RF_DW = 32;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_CAP  = 2'd1,
    S_WAIT = 2'd2
  } scan_state_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_e;

  // Round-robin tie-break: the requester that did not win last time goes next.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_CORE) ? REQ_DBG : REQ_CORE;
  endfunction

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Write-request bundle for the two RF write masters (core writeback and debug writer).
// Requesters drive valid/addr/data; the arbiter answers with a per-master ready.
interface rf_port_arbiter_if
  import rf_port_arbiter_pkg::*;
#(
  parameter int unsigned AW = RF_AW,
  parameter int unsigned DW = RF_DW
);

  logic          core_wr_valid;
  logic          core_wr_ready;
  logic [AW-1:0] core_wr_addr;
  logic [DW-1:0] core_wr_data;

  logic          dbg_wr_valid;
  logic          dbg_wr_ready;
  logic [AW-1:0] dbg_wr_addr;
  logic [DW-1:0] dbg_wr_data;

  modport master (
    output core_wr_valid, core_wr_addr, core_wr_data,
    output dbg_wr_valid,  dbg_wr_addr,  dbg_wr_data,
    input  core_wr_ready, dbg_wr_ready
  );

  modport slave (
    input  core_wr_valid, core_wr_addr, core_wr_data,
    input  dbg_wr_valid,  dbg_wr_addr,  dbg_wr_data,
    output core_wr_ready, dbg_wr_ready
  );

endinterface

// File: rtl/rf_scan_seq.sv
// Debug register scanner: walks RF read port 1 and captures one register every SCAN_DIV cycles.
// SCAN_DIV must be at least 2 (one capture cycle plus at least one wait cycle).
module rf_scan_seq
  import rf_port_arbiter_pkg::*;
#(
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dbg_mode,
  input  logic [DW-1:0] rf_rd,
  output scan_state_e   state,
  output logic [AW-1:0] ptr,
  output logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_data,
  output logic          scan_valid
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV - 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 2);

  logic [DIV_W-1:0] div;

  // Capture FSM; leaving debug mode always parks in S_OFF and keeps the last capture visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_OFF;
      ptr        <= '0;
      div        <= '0;
      scan_addr  <= '0;
      scan_data  <= '0;
      scan_valid <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      if (!dbg_mode) begin
        state <= S_OFF;
      end else begin
        case (state)
          S_OFF: begin
            state <= S_CAP;
            ptr   <= '0;
            div   <= '0;
          end
          S_CAP: begin
            scan_data  <= rf_rd;
            scan_addr  <= ptr;
            scan_valid <= 1'b1;
            ptr        <= ptr + AW'(1);
            div        <= '0;
            state      <= S_WAIT;
          end
          S_WAIT: begin
            div <= div + DIV_W'(1);
            if (div == DIV_LAST) begin
              state <= S_CAP;
            end
          end
          default: begin
            state <= S_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter for the single RF write port, plus debug-mode ownership of RF read port 1.
// Core writes are locked out in debug mode; a scanner streams register contents to the display.
module rf_port_arbiter
  import rf_port_arbiter_pkg::*;
#(
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          ZERO_R0  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dbg_mode,
  rf_port_arbiter_if.slave     wr,
  input  logic [AW-1:0]        core_ra,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd,
  output logic [AW-1:0]        rf_ra,
  input  logic [DW-1:0]        rf_rd,
  output logic [AW-1:0]        scan_addr,
  output logic [DW-1:0]        scan_data,
  output logic                 scan_valid
);

  req_id_e       last;
  logic          core_elig;
  logic          dbg_elig;
  logic          grant_core;
  logic          grant_dbg;
  logic          xfer;
  logic          drop_zero;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  scan_state_e   scan_state;
  logic [AW-1:0] scan_ptr;

  // Grant selection; ready is purely combinational so a held request completes in the same cycle.
  always_comb begin
    core_elig  = wr.core_wr_valid && !dbg_mode;
    dbg_elig   = wr.dbg_wr_valid;
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    if (core_elig && dbg_elig) begin
      grant_core = (other_req(last) == REQ_CORE);
      grant_dbg  = !grant_core;
    end else begin
      grant_core = core_elig;
      grant_dbg  = dbg_elig;
    end
  end

  assign wr.core_wr_ready = grant_core;
  assign wr.dbg_wr_ready  = grant_dbg;

  assign xfer     = grant_core || grant_dbg;
  assign sel_addr = grant_dbg ? wr.dbg_wr_addr : wr.core_wr_addr;
  assign sel_data = grant_dbg ? wr.dbg_wr_data : wr.core_wr_data;
  // Writes to r0 still complete the handshake but never reach the RF.
  assign drop_zero = ZERO_R0 && (sel_addr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last  <= REQ_DBG;
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= xfer && !drop_zero;
      if (xfer) begin
        last  <= grant_core ? REQ_CORE : REQ_DBG;
        rf_wa <= sel_addr;
        rf_wd <= sel_data;
      end
    end
  end

  rf_scan_seq #(
    .AW       (AW),
    .DW       (DW),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .dbg_mode   (dbg_mode),
    .rf_rd      (rf_rd),
    .state      (scan_state),
    .ptr        (scan_ptr),
    .scan_addr  (scan_addr),
    .scan_data  (scan_data),
    .scan_valid (scan_valid)
  );

  assign rf_ra = (scan_state == S_OFF) ? core_ra : scan_ptr;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Scoreboarded bench for rf_port_arbiter: directed scenarios followed by randomized traffic.
module tb_rf_port_arbiter;
  import rf_port_arbiter_pkg::*;

  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 32;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned NREG     = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          dbg_mode;
  logic [AW-1:0] core_ra;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [AW-1:0] rf_ra;
  logic [DW-1:0] rf_rd;
  logic [AW-1:0] scan_addr;
  logic [DW-1:0] scan_data;
  logic          scan_valid;

  rf_port_arbiter_if #(.AW(AW), .DW(DW)) wr ();

  rf_port_arbiter #(
    .AW(AW), .DW(DW), .SCAN_DIV(SCAN_DIV), .ZERO_R0(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .dbg_mode(dbg_mode), .wr(wr), .core_ra(core_ra),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra(rf_ra), .rf_rd(rf_rd),
    .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid)
  );

  always #5 clk = ~clk;

  // Register file the block is attached to.
  logic [DW-1:0] rf_mem [NREG];
  logic          preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NREG; i++) rf_mem[i] <= DW'(i);
    end else if (rf_we) begin
      rf_mem[rf_wa] <= rf_wd;
    end
  end
  assign rf_rd = rf_mem[rf_ra];

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int            stamp;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t wr_q[$];
  exp_t sc_q[$];
  exp_t mon_w;
  exp_t mon_s;

  // Reference model state.
  req_id_e       m_last;
  bit            sc_on;
  int            sc_ptr;
  int            sc_next;
  logic [DW-1:0] sc_last;
  logic [DW-1:0] ref_rf [NREG];
  bit            pend_v;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;

  // Stimulus state: a request stays up until its ready is observed.
  bit            c_v, d_v, dm;
  logic [AW-1:0] c_a, d_a, cra;
  logic [DW-1:0] c_d, d_d;
  logic          s_cr, s_dr;

  task automatic reset_model();
    m_last  = REQ_DBG;
    sc_on   = 1'b0;
    sc_ptr  = 0;
    sc_next = 0;
    sc_last = '0;
    pend_v  = 1'b0;
    c_v = 1'b0; d_v = 1'b0; dm = 1'b0;
    wr_q.delete();
    sc_q.delete();
  endtask

  // One clock of stimulus: called at a falling edge, returns at the next falling edge.
  task automatic step();
    int            e;
    bit            core_ok, dbg_ok, g_core, g_dbg;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] exp_ra;
    wr.core_wr_valid = c_v;
    wr.core_wr_addr  = c_a;
    wr.core_wr_data  = c_d;
    wr.dbg_wr_valid  = d_v;
    wr.dbg_wr_addr   = d_a;
    wr.dbg_wr_data   = d_d;
    dbg_mode         = dm;
    core_ra          = cra;
    #4;
    e = edges + 1;
    core_ok = c_v && !dm;
    dbg_ok  = d_v;
    g_core = 1'b0;
    g_dbg  = 1'b0;
    if (core_ok && dbg_ok) begin
      if (m_last == REQ_DBG) g_core = 1'b1;
      else                   g_dbg  = 1'b1;
    end else if (core_ok) begin
      g_core = 1'b1;
    end else if (dbg_ok) begin
      g_dbg = 1'b1;
    end
    s_cr = wr.core_wr_ready;
    s_dr = wr.dbg_wr_ready;
    chk("core_wr_ready", 64'(s_cr), 64'(g_core));
    chk("dbg_wr_ready", 64'(s_dr), 64'(g_dbg));
    exp_ra = sc_on ? AW'(sc_ptr) : cra;
    chk("rf_ra", 64'(rf_ra), 64'(exp_ra));
    // Scanner at this edge reads the RF before any write landing on the same edge.
    if (!dm) begin
      sc_on = 1'b0;
    end else if (!sc_on) begin
      sc_on   = 1'b1;
      sc_ptr  = 0;
      sc_next = e + 1;
    end else if (e == sc_next) begin
      sc_q.push_back('{stamp: e, a: AW'(sc_ptr), d: ref_rf[sc_ptr]});
      sc_last = ref_rf[sc_ptr];
      sc_ptr  = (sc_ptr + 1) % NREG;
      sc_next = e + SCAN_DIV;
    end
    if (pend_v) ref_rf[pend_a] = pend_d;
    pend_v = 1'b0;
    if (g_core || g_dbg) begin
      a = g_core ? c_a : d_a;
      d = g_core ? c_d : d_d;
      m_last = g_core ? REQ_CORE : REQ_DBG;
      if (a != '0) begin
        wr_q.push_back('{stamp: e, a: a, d: d});
        pend_v = 1'b1;
        pend_a = a;
        pend_d = d;
      end
    end
    @(negedge clk);
    if (g_core) c_v = 1'b0;
    if (g_dbg)  d_v = 1'b0;
  endtask

  // Monitor: compares registered outputs against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_q.size() != 0 && wr_q[0].stamp == edges) begin
        mon_w = wr_q.pop_front();
        chk("rf_we", 64'(rf_we), 64'(1));
        chk("rf_wa", 64'(rf_wa), 64'(mon_w.a));
        chk("rf_wd", 64'(rf_wd), 64'(mon_w.d));
      end else begin
        chk("rf_we_idle", 64'(rf_we), 64'(0));
      end
      if (sc_q.size() != 0 && sc_q[0].stamp == edges) begin
        mon_s = sc_q.pop_front();
        chk("scan_valid", 64'(scan_valid), 64'(1));
        chk("scan_addr", 64'(scan_addr), 64'(mon_s.a));
        chk("scan_data", 64'(scan_data), 64'(mon_s.d));
      end else begin
        chk("scan_valid_idle", 64'(scan_valid), 64'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cap7;
    int hits;
    rst = 1'b1;
    preload = 1'b1;
    dbg_mode = 1'b0;
    core_ra = '0;
    cra = '0;
    c_a = '0; c_d = '0; d_a = '0; d_d = '0;
    wr.core_wr_valid = 1'b0; wr.core_wr_addr = '0; wr.core_wr_data = '0;
    wr.dbg_wr_valid  = 1'b0; wr.dbg_wr_addr  = '0; wr.dbg_wr_data  = '0;
    for (int i = 0; i < NREG; i++) ref_rf[i] = DW'(i);
    reset_model();
    @(negedge clk);
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_rf_wa", 64'(rf_wa), 64'(0));
    chk("rst_rf_wd", 64'(rf_wd), 64'(0));
    chk("rst_scan_addr", 64'(scan_addr), 64'(0));
    chk("rst_scan_data", 64'(scan_data), 64'(0));
    chk("rst_scan_valid", 64'(scan_valid), 64'(0));
    @(negedge clk);
    preload = 1'b0;
    rst = 1'b0;

    // Asynchronous reset while a write is on the RF port.
    c_v = 1'b1; c_a = AW'(9); c_d = 32'h0909_0909;
    step();
    chk("pre_rst_rf_we", 64'(rf_we), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rf_we", 64'(rf_we), 64'(0));
    chk("async_rst_rf_wa", 64'(rf_wa), 64'(0));
    chk("async_rst_rf_wd", 64'(rf_wd), 64'(0));
    reset_model();
    @(negedge clk);
    rst = 1'b0;

    // Tie right after reset: core first, then debug.
    c_v = 1'b1; c_a = AW'(3); c_d = 32'hAAAA_0003;
    d_v = 1'b1; d_a = AW'(4); d_d = 32'hBBBB_0004;
    step();
    chk("tie_core_first", 64'(s_cr), 64'(1));
    chk("tie_wa0", 64'(rf_wa), 64'(3));
    chk("tie_wd0", 64'(rf_wd), 64'(32'hAAAA_0003));
    step();
    chk("tie_dbg_second", 64'(s_dr), 64'(1));
    chk("tie_wa1", 64'(rf_wa), 64'(4));
    chk("tie_wd1", 64'(rf_wd), 64'(32'hBBBB_0004));
    step();

    // Debug freeze of a held core request.
    dm = 1'b1;
    c_v = 1'b1; c_a = AW'(5); c_d = 32'h5555_0005;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("freeze_ready", 64'(s_cr), 64'(0));
      chk("freeze_rf_we", 64'(rf_we), 64'(0));
    end
    dm = 1'b0;
    step();
    chk("unfreeze_ready", 64'(s_cr), 64'(1));
    chk("unfreeze_rf_we", 64'(rf_we), 64'(1));
    chk("unfreeze_rf_wa", 64'(rf_wa), 64'(5));

    // Write to r0 handshakes but never reaches the RF.
    d_v = 1'b1; d_a = '0; d_d = 32'hFFFF_FFFF;
    step();
    chk("r0_ready", 64'(s_dr), 64'(1));
    chk("r0_rf_we", 64'(rf_we), 64'(0));
    step();

    // Scanner over a preloaded RF, through the wrap, then stopped mid-scan.
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int i = 0; i < NREG; i++) ref_rf[i] = DW'(i);
    dm = 1'b1;
    for (int i = 0; i < NREG * SCAN_DIV + 6; i++) begin
      cra = AW'($urandom);
      step();
    end
    dm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cra = AW'($urandom);
      step();
    end
    chk("scan_hold_data", 64'(scan_data), 64'(sc_last));

    // Write and capture of r7 on the same edge: old value first, new value next lap.
    dm = 1'b1;
    cap7 = -1;
    hits = 0;
    for (int i = 0; i < 400; i++) begin
      if (cap7 < 0 && sc_on && sc_ptr == 7 && sc_next == edges + 2) begin
        d_v = 1'b1; d_a = AW'(7); d_d = 32'h1234_5678;
        cap7 = edges + 2;
      end
      step();
      if (cap7 >= 0 && edges == cap7) begin
        hits++;
        chk("collide_addr", 64'(scan_addr), 64'(7));
        chk("collide_old", 64'(scan_data), 64'(7));
      end
      if (cap7 >= 0 && edges == cap7 + int'(NREG * SCAN_DIV)) begin
        hits++;
        chk("collide_new_addr", 64'(scan_addr), 64'(7));
        chk("collide_new", 64'(scan_data), 64'(32'h1234_5678));
        break;
      end
    end
    chk("collide_seen", 64'(hits), 64'(2));
    dm = 1'b0;
    step();

    // Randomized traffic with debug mode toggling.
    for (int n = 0; n < 700; n++) begin
      if (!c_v && $urandom_range(1, 0) == 1) begin
        c_v = 1'b1; c_a = AW'($urandom); c_d = $urandom;
      end
      if (!d_v && $urandom_range(2, 0) == 0) begin
        d_v = 1'b1;
        d_a = ($urandom_range(7, 0) == 0) ? '0 : AW'($urandom);
        d_d = $urandom;
      end
      if ($urandom_range(39, 0) == 0) dm = !dm;
      cra = AW'($urandom);
      step();
    end
    dm = 1'b0;
    for (int i = 0; i < 10 && (c_v || d_v); i++) step();
    chk("drain_requests", 64'(c_v || d_v), 64'(0));
    c_v = 1'b0; d_v = 1'b0;
    repeat (3) step();
    chk("wr_q_empty", 64'(wr_q.size()), 64'(0));
    chk("sc_q_empty", 64'(sc_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
